uart_rx: RTL

//  Serial receive engine of the UART. Oversamples RX, finds start bits, shifts in LSB-first

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by uart_rx and (later) uart_tx.
package uart_pkg;
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Host-side signals of the UART receiver. The master modport is the register file / bench side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic                 RX;
  logic [DIV_W-1:0]     DIVISOR;
  logic                 RD_ACK;
  logic [DATA_BITS-1:0] DATA_OUT;
  logic                 RXRDY;
  logic                 FERR;
  logic                 OVERRUN;
  logic                 PERR;

  modport master (
    output RX, DIVISOR, RD_ACK,
    input  DATA_OUT, RXRDY, FERR, OVERRUN, PERR
  );

  modport slave (
    input  RX, DIVISOR, RD_ACK,
    output DATA_OUT, RXRDY, FERR, OVERRUN, PERR
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-cycle tick every max(DIVISOR,1) CLK cycles.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DIV_W-1:0] DIVISOR,
  output logic             tick
);
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_reload;
  logic             r_tick;

  assign w_reload = (DIVISOR == '0) ? DIV_W'(1) : DIVISOR;
  assign tick     = r_tick;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt  <= w_reload;
      r_tick <= 1'b0;
    end else if (r_cnt <= DIV_W'(1)) begin
      r_cnt  <= w_reload;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - DIV_W'(1);
      r_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receive engine: oversampled start detection, LSB-first shift, status flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      CLK,
  input  logic      RESET,
  uart_rx_if.slave  bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_tick;
  logic                 w_rx_s;
  logic                 w_samp_done;
  rx_state_t            r_state;
  logic                 r_sync1, r_sync2, r_rx_prev;
  logic [SW-1:0]        r_samp;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop;
  logic                 r_deliver;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rxrdy, r_ferr, r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_perr;
  assign bus.PERR = r_perr;
`else
  assign bus.PERR = 1'b0;
`endif

  uart_baud_tick u_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .DIVISOR (bus.DIVISOR),
    .tick    (w_tick)
  );

  assign w_rx_s       = r_sync2;
  assign bus.DATA_OUT = r_data;
  assign bus.RXRDY    = r_rxrdy;
  assign bus.FERR     = r_ferr;
  assign bus.OVERRUN  = r_overrun;

  // Start bit is sampled half a bit in; every later bit a full bit apart.
  always_comb begin
    w_samp_done = 1'b0;
    if (w_tick)
      w_samp_done = (r_samp == ((r_state == RX_START) ? SAMP_HALF : SAMP_LAST));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= RX_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_samp    <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_stop    <= 1'b0;
      r_deliver <= 1'b0;
      r_data    <= '0;
      r_rxrdy   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_sync1   <= bus.RX;
      r_sync2   <= r_sync1;
      r_rx_prev <= w_rx_s;
      r_deliver <= 1'b0;

      if (w_tick && r_state != RX_IDLE)
        r_samp <= w_samp_done ? '0 : r_samp + SW'(1);

      case (r_state)
        RX_IDLE: begin
          // Edge-triggered so a line held low (break) never restarts a frame.
          if (r_rx_prev && !w_rx_s) begin
            r_samp  <= '0;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_samp_done) begin
            r_bitcnt <= '0;
            r_state  <= w_rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_samp_done) begin
            r_shift  <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + BW'(1);
            if (r_bitcnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (w_samp_done) begin
            r_par_bit <= w_rx_s;
            r_state   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (w_samp_done) begin
            r_stop    <= w_rx_s;
            r_deliver <= 1'b1;
            r_state   <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase

      // A delivery in the same cycle as RD_ACK replaces the pending byte.
      if (r_deliver) begin
        if (!r_rxrdy || bus.RD_ACK) begin
          r_data    <= r_shift;
          r_rxrdy   <= 1'b1;
          r_ferr    <= ~r_stop;
          r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_perr    <= (^r_shift) ^ r_par_bit;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (bus.RD_ACK && r_rxrdy) begin
        r_rxrdy   <= 1'b0;
        r_ferr    <= 1'b0;
        r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_perr    <= 1'b0;
`endif
      end
    end
  end
endmodule
